// File: rtl/dmem_port_sched_pkg.sv
// Shared widths, FSM encoding and slot-select type for the dual-issue data-memory port scheduler.
package dmem_port_sched_pkg;

    localparam int DMS_AW = 32;
    localparam int DMS_DW = 32;

    localparam logic [1:0] DMS_IDLE   = 2'd0;
    localparam logic [1:0] DMS_SECOND = 2'd1;
    localparam logic [1:0] DMS_WAIT   = 2'd2;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_SLOT1 = 2'd1,
        SEL_SLOT2 = 2'd2
    } dms_sel_e;

endpackage

// File: rtl/dmem_port_sched_if.sv
// Pipeline-side requests, SRAM port and MEM-stage load data of the scheduler, grouped as one bundle.
interface dmem_port_sched_if
    import dmem_port_sched_pkg::*;
#(
    parameter int AW = DMS_AW,
    parameter int DW = DMS_DW
) ();

    logic              flush;
    logic              hold_i;
    logic              req_en_i1;
    logic              req_en_i2;
    logic [DW/8-1:0]   req_wen_i1;
    logic [DW/8-1:0]   req_wen_i2;
    logic [AW-1:0]     req_addr_i1;
    logic [AW-1:0]     req_addr_i2;
    logic [DW-1:0]     req_wdata_i1;
    logic [DW-1:0]     req_wdata_i2;
    logic              kill_i2;
    logic              data_sram_en;
    logic [DW/8-1:0]   data_sram_wen;
    logic [AW-1:0]     data_sram_addr;
    logic [DW-1:0]     data_sram_wdata;
    logic [DW-1:0]     data_sram_rdata;
    logic              stall_req;
    logic [DW-1:0]     rdata_i1;
    logic [DW-1:0]     rdata_i2;

    // master = pipeline plus SRAM environment, slave = the scheduler
    modport master (
        output flush, hold_i, req_en_i1, req_en_i2, req_wen_i1, req_wen_i2,
               req_addr_i1, req_addr_i2, req_wdata_i1, req_wdata_i2, kill_i2,
               data_sram_rdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
               stall_req, rdata_i1, rdata_i2
    );

    modport slave (
        input  flush, hold_i, req_en_i1, req_en_i2, req_wen_i1, req_wen_i2,
               req_addr_i1, req_addr_i2, req_wdata_i1, req_wdata_i2, kill_i2,
               data_sram_rdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
               stall_req, rdata_i1, rdata_i2
    );

endinterface

// File: rtl/dmem_port_sched_req_mux.sv
// Slot select onto the single SRAM port; purely combinational, zero latency, no backpressure.
// An unselected port drives all zeros so idle cycles never show stale addresses or data.
module dms_req_mux
    import dmem_port_sched_pkg::*;
#(
    parameter int AW = DMS_AW,
    parameter int DW = DMS_DW
) (
    input  dms_sel_e          sel,
    input  logic [DW/8-1:0]   wen1,
    input  logic [DW/8-1:0]   wen2,
    input  logic [AW-1:0]     addr1,
    input  logic [AW-1:0]     addr2,
    input  logic [DW-1:0]     wdata1,
    input  logic [DW-1:0]     wdata2,
    output logic              en,
    output logic [DW/8-1:0]   wen,
    output logic [AW-1:0]     addr,
    output logic [DW-1:0]     wdata
);

    always_comb begin
        en    = 1'b0;
        wen   = '0;
        addr  = '0;
        wdata = '0;
        case (sel)
            SEL_SLOT1: begin
                en    = 1'b1;
                wen   = wen1;
                addr  = addr1;
                wdata = wdata1;
            end
            SEL_SLOT2: begin
                en    = 1'b1;
                wen   = wen2;
                addr  = addr2;
                wdata = wdata2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_port_sched.sv
// Serialises a dual-issue memory pair onto one SRAM port; single access adds 0 cycles, a dual pair adds 1.
// Backpressure: stall_req for one cycle per dual pair; hold_i freezes issue, flush aborts the pair.
module dmem_port_sched
    import dmem_port_sched_pkg::*;
#(
    parameter int AW = DMS_AW,
    parameter int DW = DMS_DW
) (
    input logic               clk,
    input logic               rst,
    dmem_port_sched_if.slave  bus
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          dual_r;
    logic          hold2_v;
    logic [DW-1:0] hold1;
    logic [DW-1:0] hold2;
    logic          dual_pair;
    logic          stall;
    dms_sel_e      sel;

    assign dual_pair = bus.req_en_i1 & bus.req_en_i2 & ~bus.kill_i2;

    always_comb begin
        sel       = SEL_NONE;
        stall     = 1'b0;
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = DMS_IDLE;
        end else begin
            case (state)
                DMS_IDLE: begin
                    if (!bus.hold_i) begin
                        if (dual_pair) begin
                            sel       = SEL_SLOT1;
                            stall     = 1'b1;
                            state_nxt = DMS_SECOND;
                        end else if (bus.req_en_i1) begin
                            sel = SEL_SLOT1;
                        end else if (bus.req_en_i2 && !bus.kill_i2) begin
                            sel = SEL_SLOT2;
                        end
                    end
                end
                DMS_SECOND: begin
                    sel       = SEL_SLOT2;
                    state_nxt = bus.hold_i ? DMS_WAIT : DMS_IDLE;
                end
                DMS_WAIT: begin
                    if (!bus.hold_i) state_nxt = DMS_IDLE;
                end
                default: state_nxt = DMS_IDLE;
            endcase
        end
        // reset must silence the port immediately, not only after the next edge
        if (!rst) begin
            sel   = SEL_NONE;
            stall = 1'b0;
        end
    end

    dms_req_mux #(
        .AW (AW),
        .DW (DW)
    ) u_req_mux (
        .sel    (sel),
        .wen1   (bus.req_wen_i1),
        .wen2   (bus.req_wen_i2),
        .addr1  (bus.req_addr_i1),
        .addr2  (bus.req_addr_i2),
        .wdata1 (bus.req_wdata_i1),
        .wdata2 (bus.req_wdata_i2),
        .en     (bus.data_sram_en),
        .wen    (bus.data_sram_wen),
        .addr   (bus.data_sram_addr),
        .wdata  (bus.data_sram_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DMS_IDLE;
            dual_r  <= 1'b0;
            hold2_v <= 1'b0;
            hold1   <= '0;
            hold2   <= '0;
        end else begin
            state <= state_nxt;
            if (bus.flush) begin
                dual_r  <= 1'b0;
                hold2_v <= 1'b0;
            end else begin
                case (state)
                    DMS_IDLE: begin
                        // the pair sitting in MEM this cycle is the one that used hold2
                        hold2_v <= 1'b0;
                        if (!bus.hold_i) dual_r <= dual_pair;
                    end
                    DMS_SECOND: hold1 <= bus.data_sram_rdata;
                    DMS_WAIT: begin
                        // slot-2 data is only on the SRAM bus in the first WAIT cycle
                        if (!hold2_v) begin
                            hold2   <= bus.data_sram_rdata;
                            hold2_v <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.stall_req = stall;
    assign bus.rdata_i1  = !rst ? '0 : (dual_r  ? hold1 : bus.data_sram_rdata);
    assign bus.rdata_i2  = !rst ? '0 : (hold2_v ? hold2 : bus.data_sram_rdata);

endmodule

// File: tb/tb_dmem_port_sched.sv
// Random issue pairs against a pair-level reference: SRAM op order, stall count and MEM-stage load data.
module tb_dmem_port_sched;
    import dmem_port_sched_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic        en1;
        logic        en2;
        logic        kill;
        logic [3:0]  wen1;
        logic [3:0]  wen2;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] d1;
        logic [31:0] d2;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_port_sched_if #(.AW(AW), .DW(DW)) bus ();

    dmem_port_sched #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5C3_0000 ^ (i * 32'h0101_0137);
    endfunction

    // SRAM: one-cycle read latency, byte-lane writes; contents seeded while reset is low
    logic [31:0] sram [16];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) sram[i] <= init_word(i);
            bus.data_sram_rdata <= '0;
        end else if (bus.data_sram_en) begin
            bus.data_sram_rdata <= sram[bus.data_sram_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (bus.data_sram_wen[b])
                    sram[bus.data_sram_addr[5:2]][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
        end
    end

    logic [31:0] ref_mem [16];

    task automatic drive(input pair_t pr, input logic h, input logic f);
        bus.req_en_i1    = pr.en1;
        bus.req_en_i2    = pr.en2;
        bus.kill_i2      = pr.kill;
        bus.req_wen_i1   = pr.wen1;
        bus.req_wen_i2   = pr.wen2;
        bus.req_addr_i1  = pr.a1;
        bus.req_addr_i2  = pr.a2;
        bus.req_wdata_i1 = pr.d1;
        bus.req_wdata_i2 = pr.d2;
        bus.hold_i       = h;
        bus.flush        = f;
    endtask

    task automatic ref_access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                              output logic [31:0] rd);
        rd = ref_mem[a[5:2]];
        for (int b = 0; b < 4; b++)
            if (w[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    pair_t       pr;
    pair_t       idle_pr;
    logic [31:0] exp_addr [2];
    logic [35:0] exp_wd   [2];
    int          exp_n, n_ops, n_stall, cyc, fat;
    logic        doomed, dual, done, flushed, hold;
    logic        pend_v, pend1, pend2;
    logic [31:0] pend_d1, pend_d2, e1, e2;

    task automatic check_pending();
        if (pend_v) begin
            if (pend1) check_eq("rdata_i1", bus.rdata_i1, pend_d1);
            if (pend2) check_eq("rdata_i2", bus.rdata_i2, pend_d2);
            pend_v = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        idle_pr = '{en1: 1'b0, en2: 1'b0, kill: 1'b0, wen1: 4'h0, wen2: 4'h0,
                    a1: 32'h0, a2: 32'h0, d1: 32'h0, d2: 32'h0};
        pend_v = 1'b0;

        // reset with a dual store pair presented: every output must stay zero
        pr = '{en1: 1'b1, en2: 1'b1, kill: 1'b0, wen1: 4'hF, wen2: 4'hF,
               a1: 32'h104, a2: 32'h108, d1: 32'h1234_5678, d2: 32'h9ABC_DEF0};
        drive(pr, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_en",    bus.data_sram_en,    0);
        check_eq("rst_wen",   bus.data_sram_wen,   0);
        check_eq("rst_addr",  bus.data_sram_addr,  0);
        check_eq("rst_wdata", bus.data_sram_wdata, 0);
        check_eq("rst_stall", bus.stall_req,       0);
        check_eq("rst_rd1",   bus.rdata_i1,        0);
        check_eq("rst_rd2",   bus.rdata_i2,        0);
        drive(idle_pr, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int p = 0; p < 400; p++) begin
            doomed  = ($urandom_range(0, 7) == 0);
            fat     = $urandom_range(0, 2);
            pr.en1  = ($urandom_range(0, 9) < 7);
            pr.en2  = ($urandom_range(0, 9) < 7);
            pr.kill = ($urandom_range(0, 4) == 0);
            pr.wen1 = (doomed || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            pr.wen2 = (doomed || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            pr.a1   = 32'h100 + 32'($urandom_range(0, 15) * 4);
            pr.a2   = 32'h100 + 32'($urandom_range(0, 15) * 4);
            pr.d1   = $urandom;
            pr.d2   = $urandom;

            // reference: slot 1 then slot 2 (unless killed), each exactly once, in program order
            exp_n = 0;
            e1 = '0;
            e2 = '0;
            if (pr.en1) begin
                exp_addr[exp_n] = pr.a1;
                exp_wd[exp_n]   = {pr.wen1, pr.wen1 != 0 ? pr.d1 : 32'h0};
                exp_n++;
                ref_access(pr.a1, pr.wen1, pr.d1, e1);
            end
            if (pr.en2 && !pr.kill) begin
                exp_addr[exp_n] = pr.a2;
                exp_wd[exp_n]   = {pr.wen2, pr.wen2 != 0 ? pr.d2 : 32'h0};
                exp_n++;
                ref_access(pr.a2, pr.wen2, pr.d2, e2);
            end
            dual = pr.en1 && pr.en2 && !pr.kill;

            cyc = 0; n_ops = 0; n_stall = 0; done = 1'b0; flushed = 1'b0;
            while (!done && cyc < 40) begin
                @(posedge clk);
                #1;
                hold = ($urandom_range(0, 3) == 0);
                drive(pr, hold, doomed && cyc == fat);
                @(negedge clk);
                check_pending();
                if (bus.flush) begin
                    check_eq("flush_en",    bus.data_sram_en, 0);
                    check_eq("flush_stall", bus.stall_req,    0);
                    done    = 1'b1;
                    flushed = 1'b1;
                end else begin
                    if (bus.data_sram_en) begin
                        if (n_ops < exp_n) begin
                            check_eq("op_addr", bus.data_sram_addr, exp_addr[n_ops]);
                            check_eq("op_wen_wdata",
                                     {bus.data_sram_wen, bus.data_sram_wen != 0 ? bus.data_sram_wdata : 32'h0},
                                     exp_wd[n_ops]);
                        end else begin
                            check_eq("extra_op", 1, 0);
                        end
                        n_ops++;
                    end
                    if (bus.stall_req) n_stall++;
                    if (!bus.hold_i && !bus.stall_req) done = 1'b1;
                end
                cyc++;
            end
            if (!done) check_eq("pair_timeout", 0, 1);
            if (!flushed) begin
                check_eq("op_count",     n_ops,   exp_n);
                check_eq("stall_cycles", n_stall, dual ? 1 : 0);
                pend_v  = 1'b1;
                pend1   = pr.en1 && pr.wen1 == 0;
                pend2   = pr.en2 && !pr.kill && pr.wen2 == 0;
                pend_d1 = e1;
                pend_d2 = e2;
            end
        end

        @(posedge clk);
        #1;
        drive(idle_pr, 1'b0, 1'b0);
        @(negedge clk);
        check_pending();

        // asynchronous reset in the middle of the slot-2 issue
        @(posedge clk);
        #1;
        pr = '{en1: 1'b1, en2: 1'b1, kill: 1'b0, wen1: 4'h0, wen2: 4'h0,
               a1: 32'h100, a2: 32'h104, d1: 32'h0, d2: 32'h0};
        drive(pr, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("mid_stall", bus.stall_req, 1);
        @(posedge clk);
        #1;
        check_eq("mid_second_addr", bus.data_sram_addr, 32'h104);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_en",    bus.data_sram_en,    0);
        check_eq("arst_addr",  bus.data_sram_addr,  0);
        check_eq("arst_wen",   bus.data_sram_wen,   0);
        check_eq("arst_stall", bus.stall_req,       0);
        check_eq("arst_rd1",   bus.rdata_i1,        0);
        check_eq("arst_rd2",   bus.rdata_i2,        0);
        drive(idle_pr, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // after reset the FSM is back in IDLE: a single load issues at once with no stall
        @(posedge clk);
        #1;
        pr = idle_pr;
        pr.en1 = 1'b1;
        pr.a1  = 32'h10C;
        drive(pr, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("post_rst_en",    bus.data_sram_en, 1);
        check_eq("post_rst_stall", bus.stall_req,    0);
        @(posedge clk);
        #1;
        drive(idle_pr, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("post_rst_rd1", bus.rdata_i1, ref_mem[3]);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
